// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message padder and its fill helper.
package sha256_pkg;

    typedef logic [511:0] sha_block_t;
    typedef logic [31:0]  sha_word_t;

    localparam int         BLOCK_BYTES = 64;
    localparam int         LEN_OFFSET  = 56;
    localparam logic [7:0] PAD_BYTE    = 8'h80;

    typedef enum logic [1:0] {
        FILL,
        EMIT,
        WAIT,
        PAD
    } padder_state_t;

    // Bit position of message byte k: word k/4, big-endian inside the word.
    function automatic int byteLsb(input int k);
        return 32 * (k / 4) + 8 * (3 - (k % 4));
    endfunction

endpackage

// File: rtl/sha256_pad_fill.sv
// Combinational block finisher: 0x80 (or 0x00) at byte q, zeros after it,
// and optionally the 64-bit big-endian bit length in bytes 56..63.
module sha256_pad_fill
    import sha256_pkg::*;
(
    input  sha_block_t  i_block,
    input  logic [5:0]  i_q,
    input  logic        i_insert80,
    input  logic        i_writeLen,
    input  logic [63:0] i_len,
    output sha_block_t  o_block
);

    always_comb begin
        o_block = i_block;
        for (int k = 0; k < BLOCK_BYTES; k++) begin
            if (k == int'(i_q)) begin
                o_block[byteLsb(k) +: 8] = i_insert80 ? PAD_BYTE : 8'h00;
            end else if (k > int'(i_q)) begin
                o_block[byteLsb(k) +: 8] = 8'h00;
            end
            if (i_writeLen && (k >= LEN_OFFSET)) begin
                o_block[byteLsb(k) +: 8] = i_len[8 * (63 - k) +: 8];
            end
        end
    end

endmodule

// File: rtl/sha256_msg_padder.sv
// Packs a byte stream into 512-bit SHA-256 blocks with standard padding and
// hands each block to the hash core with a start pulse, holding it until done.
module sha256_msg_padder
    import sha256_pkg::*;
#(
    parameter int LEN_BITS = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       in_ready,
    output logic       start,
    output sha_block_t blk_data,
    output logic       blk_first,
    output logic       blk_last,
    input  logic       done,
    output logic       busy
);

    padder_state_t       r_state;
    padder_state_t       w_nextState;
    sha_block_t          r_block;
    logic [5:0]          r_ptr;
    logic [LEN_BITS-1:0] r_len;
    logic                r_first;
    logic                r_blkFirst;
    logic                r_last;
    logic                r_pendPad;
    logic                r_pend80;
    logic                r_busy;

    logic                w_accept;
    logic [5:0]          w_q;
    logic [8:0]          w_ptrLsb;
    logic [LEN_BITS-1:0] w_lenNext;
    logic [63:0]         w_fillLen;
    logic [5:0]          w_fillQ;
    logic                w_fillInsert80;
    logic                w_fillWriteLen;
    sha_block_t          w_merged;
    sha_block_t          w_fillIn;
    sha_block_t          w_padded;

    // Gated by reset so the handshake drops the instant reset is raised.
    assign in_ready  = (r_state == FILL) && !reset;
    assign start     = (r_state == EMIT);
    assign blk_data  = r_block;
    assign blk_first = r_blkFirst;
    assign blk_last  = r_last;
    assign busy      = r_busy;

    assign w_accept  = in_valid && in_ready;
    assign w_q       = r_ptr + 6'd1;
    assign w_ptrLsb  = {r_ptr[5:2], 5'd0} + {4'd0, ~r_ptr[1:0], 3'd0};
    assign w_lenNext = r_len + LEN_BITS'(8);

    always_comb begin
        w_merged = r_block;
        w_merged[w_ptrLsb +: 8] = in_data;
    end

    // The same finisher serves the last-byte path in FILL and the trailing block in PAD.
    always_comb begin
        w_fillIn       = w_merged;
        w_fillQ        = w_q;
        w_fillInsert80 = 1'b1;
        w_fillWriteLen = (w_q < 6'(LEN_OFFSET));
        w_fillLen      = 64'(w_lenNext);
        if (r_state == PAD) begin
            w_fillIn       = r_block;
            w_fillQ        = 6'd0;
            w_fillInsert80 = r_pend80;
            w_fillWriteLen = 1'b1;
            w_fillLen      = 64'(r_len);
        end
    end

    sha256_pad_fill u_padFill (
        .i_block    (w_fillIn),
        .i_q        (w_fillQ),
        .i_insert80 (w_fillInsert80),
        .i_writeLen (w_fillWriteLen),
        .i_len      (w_fillLen),
        .o_block    (w_padded)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= FILL;
        else       r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            FILL:    if (w_accept && (in_last || (w_q == 6'd0))) w_nextState = EMIT;
            EMIT:    w_nextState = WAIT;
            WAIT:    if (done) w_nextState = r_pendPad ? PAD : FILL;
            PAD:     w_nextState = EMIT;
            default: w_nextState = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_block    <= '0;
            r_ptr      <= '0;
            r_len      <= '0;
            r_first    <= 1'b1;
            r_blkFirst <= 1'b0;
            r_last     <= 1'b0;
            r_pendPad  <= 1'b0;
            r_pend80   <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            unique case (r_state)
                FILL: begin
                    if (w_accept) begin
                        r_ptr      <= w_q;
                        r_len      <= w_lenNext;
                        r_busy     <= 1'b1;
                        r_blkFirst <= r_first;
                        r_last     <= 1'b0;
                        if (in_last && (w_q != 6'd0)) begin
                            r_block   <= w_padded;
                            r_last    <= (w_q < 6'(LEN_OFFSET));
                            r_pendPad <= (w_q >= 6'(LEN_OFFSET));
                            r_pend80  <= 1'b0;
                        end else begin
                            r_block <= w_merged;
                            if (in_last) begin
                                r_pendPad <= 1'b1;
                                r_pend80  <= 1'b1;
                            end
                        end
                    end
                end
                EMIT: r_first <= 1'b0;
                WAIT: begin
                    if (done && !r_pendPad && r_last) begin
                        r_len   <= '0;
                        r_ptr   <= '0;
                        r_first <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                PAD: begin
                    r_block    <= w_padded;
                    r_pendPad  <= 1'b0;
                    r_last     <= 1'b1;
                    r_blkFirst <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed self-checking bench for sha256_msg_padder with hand-computed padded blocks.
module tb_sha256_msg_padder;
    import sha256_pkg::*;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data  = 8'h00;
    logic       in_last  = 1'b0;
    logic       done     = 1'b0;
    logic       in_ready;
    logic       start;
    logic       blk_first;
    logic       blk_last;
    logic       busy;
    sha_block_t blk_data;

    int         nAssert = 0;
    int         nFail   = 0;
    sha_block_t expBlock;

    always #5 clk = ~clk;

    sha256_msg_padder #(.LEN_BITS(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .start     (start),
        .blk_data  (blk_data),
        .blk_first (blk_first),
        .blk_last  (blk_last),
        .done      (done),
        .busy      (busy)
    );

    task automatic checkOutput(input string tag, input logic [511:0] observed, input logic [511:0] expected);
        nAssert++;
        assert (observed === expected) else begin
            nFail++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] d, input logic l);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic sendString(input string s);
        for (int i = 0; i < s.len(); i++) applyStimulus(8'(s[i]), (i == s.len() - 1));
    endtask

    task automatic sendRepeat(input logic [7:0] d, input int n);
        for (int i = 0; i < n; i++) applyStimulus(d, (i == n - 1));
    endtask

    task automatic pulseDone();
        @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset state
        @(negedge clk);
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_start", start, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_blk_data", blk_data, '0);
        checkOutput("rst_blk_first", blk_first, 0);
        checkOutput("rst_blk_last", blk_last, 0);
        reset = 1'b0;
        #1;
        checkOutput("post_rst_in_ready", in_ready, 1);

        // "1234567890": single block, start one cycle after the last byte
        sendString("1234567890");
        @(negedge clk);
        expBlock = '0;
        expBlock[0*32 +: 32]  = 32'h31323334;
        expBlock[1*32 +: 32]  = 32'h35363738;
        expBlock[2*32 +: 32]  = 32'h39308000;
        expBlock[15*32 +: 32] = 32'h00000050;
        checkOutput("t1_start", start, 1);
        checkOutput("t1_block", blk_data, expBlock);
        checkOutput("t1_first", blk_first, 1);
        checkOutput("t1_last", blk_last, 1);
        checkOutput("t1_busy", busy, 1);
        checkOutput("t1_in_ready", in_ready, 0);
        @(negedge clk);
        checkOutput("t1_start_pulse", start, 0);
        pulseDone();
        checkOutput("t1_busy_after_done", busy, 0);
        checkOutput("t1_ready_after_done", in_ready, 1);

        // "abc", then hold done off for 80 cycles with a byte waiting
        sendString("abc");
        @(negedge clk);
        expBlock = '0;
        expBlock[0*32 +: 32]  = 32'h61626380;
        expBlock[15*32 +: 32] = 32'h00000018;
        checkOutput("abc_start", start, 1);
        checkOutput("abc_block", blk_data, expBlock);
        checkOutput("abc_first", blk_first, 1);
        checkOutput("abc_last", blk_last, 1);
        in_valid = 1'b1;
        in_data  = 8'h41;
        in_last  = 1'b1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            checkOutput("hold_in_ready", in_ready, 0);
            checkOutput("hold_block", blk_data, expBlock);
            checkOutput("hold_start", start, 0);
        end
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        checkOutput("held_byte_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        expBlock = '0;
        expBlock[0*32 +: 32]  = 32'h41800000;
        expBlock[15*32 +: 32] = 32'h00000008;
        checkOutput("held_start", start, 1);
        checkOutput("held_block", blk_data, expBlock);
        checkOutput("held_first", blk_first, 1);
        checkOutput("held_last", blk_last, 1);
        pulseDone();

        // Stray done while idle in FILL emits nothing
        pulseDone();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("stray_start", start, 0);
        end
        checkOutput("stray_busy", busy, 0);
        checkOutput("stray_ready", in_ready, 1);

        // 56 x 'a': 0x80 fits, length spills into a trailing block
        sendRepeat(8'h61, 56);
        @(negedge clk);
        expBlock = '0;
        for (int w = 0; w < 14; w++) expBlock[w*32 +: 32] = 32'h61616161;
        expBlock[14*32 +: 32] = 32'h80000000;
        checkOutput("a56_b0_start", start, 1);
        checkOutput("a56_b0_block", blk_data, expBlock);
        checkOutput("a56_b0_first", blk_first, 1);
        checkOutput("a56_b0_last", blk_last, 0);
        pulseDone();
        checkOutput("a56_pad_gap_start", start, 0);
        checkOutput("a56_pad_gap_busy", busy, 1);
        @(negedge clk);
        expBlock = '0;
        expBlock[15*32 +: 32] = 32'h000001C0;
        checkOutput("a56_b1_start", start, 1);
        checkOutput("a56_b1_block", blk_data, expBlock);
        checkOutput("a56_b1_first", blk_first, 0);
        checkOutput("a56_b1_last", blk_last, 1);
        pulseDone();
        checkOutput("a56_busy_end", busy, 0);

        // 64 x 0x00: exact fill, 0x80 and length both go in the trailing block
        sendRepeat(8'h00, 64);
        @(negedge clk);
        expBlock = '0;
        checkOutput("z64_b0_start", start, 1);
        checkOutput("z64_b0_block", blk_data, expBlock);
        checkOutput("z64_b0_first", blk_first, 1);
        checkOutput("z64_b0_last", blk_last, 0);
        pulseDone();
        checkOutput("z64_pad_gap_start", start, 0);
        @(negedge clk);
        expBlock = '0;
        expBlock[0*32 +: 32]  = 32'h80000000;
        expBlock[15*32 +: 32] = 32'h00000200;
        checkOutput("z64_b1_start", start, 1);
        checkOutput("z64_b1_block", blk_data, expBlock);
        checkOutput("z64_b1_first", blk_first, 0);
        checkOutput("z64_b1_last", blk_last, 1);
        pulseDone();
        checkOutput("z64_busy_end", busy, 0);

        // Asynchronous reset while a block is outstanding
        sendString("xyz");
        @(negedge clk);
        checkOutput("xyz_start", start, 1);
        @(negedge clk);
        checkOutput("xyz_wait_busy", busy, 1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("arst_start", start, 0);
        checkOutput("arst_busy", busy, 0);
        checkOutput("arst_in_ready", in_ready, 0);
        checkOutput("arst_blk_data", blk_data, '0);
        checkOutput("arst_blk_first", blk_first, 0);
        checkOutput("arst_blk_last", blk_last, 0);
        @(negedge clk);
        reset = 1'b0;
        sendString("abc");
        @(negedge clk);
        expBlock = '0;
        expBlock[0*32 +: 32]  = 32'h61626380;
        expBlock[15*32 +: 32] = 32'h00000018;
        checkOutput("post_arst_start", start, 1);
        checkOutput("post_arst_block", blk_data, expBlock);
        checkOutput("post_arst_first", blk_first, 1);
        checkOutput("post_arst_last", blk_last, 1);
        pulseDone();
        checkOutput("post_arst_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
